// File: rtl/dbio_sb_arb.sv
// dbio_sb_arb
// Round-robin arbiter and pacer for the debug bridge immediate-send sideband.
// Up to eight on-chip requesters share a single byte channel. Each granted
// request becomes a two-byte packet: the header {5'b11110, idx} followed by
// the payload. Consecutive strobes are spaced so that the bridge's small send
// FIFO cannot overflow. While the bridge is busy with its own traffic
// (AHold=1), no byte is emitted.
//
// Ports:
//   AClkH      clock
//   AResetHN   asynchronous active-low reset
//   AClkHEn    clock enable; every register holds while 0
//   AHold      bridge busy; delays emission only
//   AReq       per-requester request level, held until acked
//   AData      payload byte of requester i at [8i+7:8i]
//   AAck       one-cycle grant pulse (payload is captured on the same edge)
//   ASbData    sideband byte
//   ASbNow     one-cycle write strobe for ASbData
//   ASbActive  pending or in-flight traffic indicator
module dbio_sb_arb #(
  parameter int CReqCnt = 4,
  parameter int CGapLen = 16
) (
  input  logic                   AClkH,
  input  logic                   AResetHN,
  input  logic                   AClkHEn,
  input  logic                   AHold,
  input  logic [CReqCnt-1:0]     AReq,
  input  logic [8*CReqCnt-1:0]   AData,
  output logic [CReqCnt-1:0]     AAck,
  output logic [7:0]             ASbData,
  output logic                   ASbNow,
  output logic                   ASbActive
);

  localparam int GW = $clog2(CGapLen);
  localparam logic [GW-1:0] GapLoad = GW'(CGapLen - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HDR   = 2'd2,
    S_PAY   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [2:0]           r_ptr;
  logic [2:0]           r_idx;
  logic [7:0]           r_payload;
  logic [GW-1:0]        r_gap;
  logic [CReqCnt-1:0]   r_ack;
  logic [7:0]           r_sbdata;
  logic                 r_sbnow;
  logic                 r_active;

  logic [2:0]           w_ptr_next;
  logic [2:0]           w_idx_next;
  logic [7:0]           w_payload_next;
  logic [GW-1:0]        w_gap_next;
  logic [CReqCnt-1:0]   w_ack_next;
  logic [7:0]           w_sbdata_next;
  logic                 w_sbnow_next;
  logic                 w_active_next;

  logic [7:0]           w_req8;
  logic                 w_found;
  logic [2:0]           w_win;
  logic [3:0]           w_pos;
  logic [7:0]           w_win_data;
  logic [CReqCnt-1:0]   w_win_onehot;
  logic                 w_emit_ok;

  // Requests padded to eight bits so a 3-bit index always selects in range.
  assign w_req8 = 8'(AReq);

  // Round-robin search: first set request at or above the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = 3'd0;
    w_pos   = 4'd0;
    for (int k = 0; k < CReqCnt; k++) begin
      w_pos = {1'b0, r_ptr} + 4'(k);
      if (w_pos >= 4'(CReqCnt)) begin
        w_pos = w_pos - 4'(CReqCnt);
      end
      if (!w_found && w_req8[w_pos[2:0]]) begin
        w_found = 1'b1;
        w_win   = w_pos[2:0];
      end
    end
  end

  always_comb begin
    w_win_data = 8'd0;
    for (int i = 0; i < CReqCnt; i++) begin
      if (w_win == 3'(i)) begin
        w_win_data = AData[8*i +: 8];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < CReqCnt; gi++) begin : g_onehot
      assign w_win_onehot[gi] = (w_win == 3'(gi));
    end
  endgenerate

  // A byte may only leave once the spacing window has expired and the bridge
  // is not sending its own traffic.
  assign w_emit_ok = (r_gap == '0) && !AHold;

  // State register
  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      r_state <= S_IDLE;
    end else if (AClkHEn) begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found)   w_state_next = S_GRANT;
      S_GRANT:                w_state_next = S_HDR;
      S_HDR:   if (w_emit_ok) w_state_next = S_PAY;
      S_PAY:   if (w_emit_ok) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  // Output / datapath next values; every output is registered below.
  always_comb begin
    w_ptr_next     = r_ptr;
    w_idx_next     = r_idx;
    w_payload_next = r_payload;
    w_ack_next     = '0;
    w_sbnow_next   = 1'b0;
    w_sbdata_next  = r_sbdata;
    w_gap_next     = (r_gap != '0) ? (r_gap - GW'(1)) : r_gap;
    w_active_next  = (r_state != S_IDLE) || (r_gap != '0) || (|AReq);
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_idx_next     = w_win;
          w_payload_next = w_win_data;
          w_ack_next     = w_win_onehot;
        end
      end
      S_GRANT: begin
        w_ptr_next = (r_idx == 3'(CReqCnt - 1)) ? 3'd0 : (r_idx + 3'd1);
      end
      S_HDR: begin
        if (w_emit_ok) begin
          w_sbnow_next  = 1'b1;
          w_sbdata_next = {5'b11110, r_idx};
          w_gap_next    = GapLoad;
        end
      end
      S_PAY: begin
        if (w_emit_ok) begin
          w_sbnow_next  = 1'b1;
          w_sbdata_next = r_payload;
          w_gap_next    = GapLoad;
        end
      end
      default: begin
        w_ptr_next = r_ptr;
      end
    endcase
  end

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      r_ptr     <= 3'd0;
      r_idx     <= 3'd0;
      r_payload <= 8'd0;
      r_gap     <= '0;
      r_ack     <= '0;
      r_sbdata  <= 8'd0;
      r_sbnow   <= 1'b0;
      r_active  <= 1'b0;
    end else if (AClkHEn) begin
      r_ptr     <= w_ptr_next;
      r_idx     <= w_idx_next;
      r_payload <= w_payload_next;
      r_gap     <= w_gap_next;
      r_ack     <= w_ack_next;
      r_sbdata  <= w_sbdata_next;
      r_sbnow   <= w_sbnow_next;
      r_active  <= w_active_next;
    end
  end

  assign AAck      = r_ack;
  assign ASbData   = r_sbdata;
  assign ASbNow    = r_sbnow;
  assign ASbActive = r_active;

endmodule

// File: tb/tb_dbio_sb_arb.sv
// Testbench for dbio_sb_arb: directed scenarios plus a randomized phase, all
// checked every clock against a packet-level reference model that tracks the
// strobe spacing with timestamps.
module tb_dbio_sb_arb;

  localparam int N    = 4;
  localparam int CGAP = 16;

  localparam int M_IDLE  = 0;
  localparam int M_GRANT = 1;
  localparam int M_HDR   = 2;
  localparam int M_PAY   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             hold;
  logic [N-1:0]     req;
  logic [8*N-1:0]   data;
  logic [N-1:0]     AAck;
  logic [7:0]       ASbData;
  logic             ASbNow;
  logic             ASbActive;

  dbio_sb_arb #(.CReqCnt(N), .CGapLen(CGAP)) dut (
    .AClkH     (clk),
    .AResetHN  (rst_n),
    .AClkHEn   (en),
    .AHold     (hold),
    .AReq      (req),
    .AData     (data),
    .AAck      (AAck),
    .ASbData   (ASbData),
    .ASbNow    (ASbNow),
    .ASbActive (ASbActive)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int edges    = 0;
  bit auto_drop = 1'b1;

  // Reference model state
  int       m_st;
  int       m_ptr;
  int       m_win;
  logic [7:0] m_pay;
  longint   m_n;
  longint   m_last;
  logic [N-1:0] exp_ack;
  logic       exp_now;
  logic [7:0] exp_data;
  logic       exp_active;

  typedef struct packed {
    logic [7:0] d;
    int         t;
  } ent_t;
  ent_t sb_log[$];
  int   ack_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st       = M_IDLE;
    m_ptr      = 0;
    m_win      = 0;
    m_pay      = 8'd0;
    m_last     = -1000;
    exp_ack    = '0;
    exp_now    = 1'b0;
    exp_data   = 8'd0;
    exp_active = 1'b0;
  endtask

  // One enabled edge: spacing is judged from the timestamp of the last strobe.
  task automatic model_step();
    bit gap_free;
    int w;
    int c;
    m_n++;
    gap_free   = (m_n - m_last) >= CGAP;
    exp_active = (m_st != M_IDLE) || !gap_free || (req != '0);
    exp_ack    = '0;
    exp_now    = 1'b0;
    case (m_st)
      M_IDLE: begin
        if (req != '0) begin
          w = -1;
          for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (w < 0 && req[c]) w = c;
          end
          m_win      = w;
          m_pay      = data[8*w +: 8];
          exp_ack[w] = 1'b1;
          m_st       = M_GRANT;
        end
      end
      M_GRANT: begin
        m_ptr = (m_win + 1) % N;
        m_st  = M_HDR;
      end
      M_HDR: begin
        if (gap_free && !hold) begin
          exp_now  = 1'b1;
          exp_data = 8'hF0 + 8'(m_win);
          m_last   = m_n;
          m_st     = M_PAY;
        end
      end
      default: begin
        if (gap_free && !hold) begin
          exp_now  = 1'b1;
          exp_data = m_pay;
          m_last   = m_n;
          m_st     = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_ack"},    32'(AAck),      32'(exp_ack));
    check({tag, "_now"},    32'(ASbNow),    32'(exp_now));
    check({tag, "_data"},   32'(ASbData),   32'(exp_data));
    check({tag, "_active"}, 32'(ASbActive), 32'(exp_active));
  endtask

  task automatic tick();
    bit en_now;
    bit rst_now;
    en_now  = en;
    rst_now = rst_n;
    if (rst_now && en_now) model_step();
    @(posedge clk);
    edges++;
    #1;
    check_outputs("cyc");
    if (en_now && rst_now && ASbNow) sb_log.push_back('{d: ASbData, t: edges});
    if (en_now && rst_now && AAck != '0) begin
      for (int i = 0; i < N; i++) if (AAck[i]) ack_log.push_back(i);
    end
    if (auto_drop) req = req & ~exp_ack;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_ack",    32'(AAck),      32'd0);
    check("rst_now",    32'(ASbNow),    32'd0);
    check("rst_data",   32'(ASbData),   32'd0);
    check("rst_active", 32'(ASbActive), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int t_rel;
    int guard;
    rst_n = 1'b0;
    en    = 1'b1;
    hold  = 1'b0;
    req   = '0;
    data  = '0;
    m_n   = 0;
    model_reset();
    #2;
    do_reset();

    // 1: single requester 2
    sb_log.delete(); ack_log.delete();
    data[23:16] = 8'h3C;
    req = 4'b0100;
    for (int i = 0; i < 60; i++) tick();
    check("t1_acks", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() >= 1) check("t1_ack_idx", 32'(ack_log[0]), 32'd2);
    check("t1_strobes", 32'(sb_log.size()), 32'd2);
    if (sb_log.size() >= 2) begin
      check("t1_hdr", 32'(sb_log[0].d), 32'hF2);
      check("t1_pay", 32'(sb_log[1].d), 32'h3C);
      check("t1_gap", 32'(sb_log[1].t - sb_log[0].t), 32'd16);
    end
    check("t1_idle_active", 32'(ASbActive), 32'd0);

    // 2: all requesters held continuously
    do_reset();
    sb_log.delete(); ack_log.delete();
    auto_drop = 1'b0;
    data = 32'h44332211;
    req  = 4'b1111;
    guard = 0;
    while (sb_log.size() < 10 && guard < 400) begin tick(); guard++; end
    req = '0;
    auto_drop = 1'b1;
    check("t2_strobes", 32'(sb_log.size()), 32'd10);
    check("t2_acks", 32'(ack_log.size()), 32'd5);
    if (ack_log.size() == 5) begin
      for (int i = 0; i < 5; i++) check("t2_order", 32'(ack_log[i]), 32'(i % N));
    end
    if (sb_log.size() == 10) begin
      for (int i = 0; i < 5; i++) check("t2_hdr", 32'(sb_log[2*i].d), 32'hF0 + 32'(i % N));
      check("t2_pay0", 32'(sb_log[1].d), 32'h11);
      check("t2_pay3", 32'(sb_log[7].d), 32'h44);
      for (int i = 1; i < 10; i++) check("t2_spacing", 32'(sb_log[i].t - sb_log[i-1].t), 32'd16);
    end
    for (int i = 0; i < 40; i++) tick();

    // 3: AHold held for 40 cycles from the moment Hdr is reached
    sb_log.delete(); ack_log.delete();
    data[15:8] = 8'h5A;
    req = 4'b0010;
    guard = 0;
    while (m_st != M_HDR && guard < 50) begin tick(); guard++; end
    check("t3_reach_hdr", 32'(m_st), 32'(M_HDR));
    hold = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    check("t3_none_held", 32'(sb_log.size()), 32'd0);
    hold  = 1'b0;
    t_rel = edges;
    for (int i = 0; i < 30; i++) tick();
    check("t3_strobes", 32'(sb_log.size()), 32'd2);
    if (sb_log.size() == 2) begin
      check("t3_hdr", 32'(sb_log[0].d), 32'hF1);
      check("t3_hdr_time", 32'(sb_log[0].t), 32'(t_rel + 1));
      check("t3_pay", 32'(sb_log[1].d), 32'h5A);
      check("t3_gap", 32'(sb_log[1].t - sb_log[0].t), 32'd16);
    end

    // 4: clock enable toggling every cycle
    sb_log.delete(); ack_log.delete();
    data[31:24] = 8'hC7;
    req = 4'b1000;
    for (int i = 0; i < 90; i++) begin
      en = (i % 2 == 0);
      tick();
    end
    en = 1'b1;
    check("t4_strobes", 32'(sb_log.size()), 32'd2);
    if (sb_log.size() == 2) begin
      check("t4_hdr", 32'(sb_log[0].d), 32'hF3);
      check("t4_pay", 32'(sb_log[1].d), 32'hC7);
      check("t4_gap_clocks", 32'(sb_log[1].t - sb_log[0].t), 32'd32);
    end
    for (int i = 0; i < 20; i++) tick();

    // 5: reset between header and payload
    sb_log.delete(); ack_log.delete();
    data[7:0] = 8'hA5;
    req = 4'b0001;
    guard = 0;
    while (!(exp_now && m_st == M_PAY) && guard < 60) begin tick(); guard++; end
    check("t5_hdr_seen", 32'(sb_log.size()), 32'd1);
    tick();
    tick();
    do_reset();
    sb_log.delete();
    for (int i = 0; i < 40; i++) tick();
    check("t5_no_payload", 32'(sb_log.size()), 32'd0);
    ack_log.delete();
    data = 32'h0D0C0B0A;
    req  = 4'b1111;
    for (int i = 0; i < 160; i++) tick();
    check("t5_acks", 32'(ack_log.size()), 32'd4);
    if (ack_log.size() == 4) begin
      for (int i = 0; i < 4; i++) check("t5_order", 32'(ack_log[i]), 32'(i));
    end
    for (int i = 0; i < 20; i++) tick();

    // 6: short-lived request from requester 1 while requester 3 is served
    sb_log.delete(); ack_log.delete();
    data[31:24] = 8'h9E;
    req = 4'b1000;
    guard = 0;
    while (m_st != M_HDR && guard < 50) begin tick(); guard++; end
    data[15:8] = 8'h77;
    req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    check("t6_acks", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() == 1) check("t6_ack_idx", 32'(ack_log[0]), 32'd3);
    check("t6_strobes", 32'(sb_log.size()), 32'd2);
    if (sb_log.size() == 2) begin
      check("t6_hdr", 32'(sb_log[0].d), 32'hF3);
      check("t6_pay", 32'(sb_log[1].d), 32'h9E);
    end

    // Randomized phase
    for (int c = 0; c < 1500; c++) begin
      en   = ($urandom_range(0, 3) != 0);
      hold = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 7) == 0) begin
          data[8*i +: 8] = 8'($urandom);
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 63) == 0) begin
          req[i] = 1'b0;
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
